// File: rtl/horner_eval_pkg.sv
// rtl/horner_eval_pkg.sv - shared state encodings and default sizes for the Horner evaluator
package horner_eval_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEGREE     = 3;
    localparam int DEF_CNT_WIDTH  = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_X_RD   = 3'd1,
        ST_X_LAT  = 3'd2,
        ST_C_WAIT = 3'd3,
        ST_C_RD   = 3'd4,
        ST_C_ACC  = 3'd5,
        ST_Y_CHK  = 3'd6,
        ST_Y_WR   = 3'd7
    } state_t;

endpackage

// File: rtl/horner_mac.sv
// rtl/horner_mac.sv - combinational Horner step: low DATA_WIDTH bits of acc*x + c (signed)
module horner_mac
    import horner_eval_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] i_acc,
    input  logic [DATA_WIDTH-1:0] i_x,
    input  logic [DATA_WIDTH-1:0] i_c,
    output logic [DATA_WIDTH-1:0] o_y
);

    // The low half of a two's-complement product does not depend on the
    // operand signs, so only DATA_WIDTH bits of the full product are formed.
    logic signed [DATA_WIDTH-1:0] w_prod;

    assign w_prod = $signed(i_acc) * $signed(i_x);
    assign o_y    = w_prod + i_c;

endmodule

// File: rtl/horner_eval.sv
// rtl/horner_eval.sv - FIFO-fed polynomial evaluator using Horner's rule, one MAC per coefficient
module horner_eval
    import horner_eval_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEGREE     = DEF_DEGREE,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] x_data,
    input  logic                  x_empty,
    output logic                  x_rd,
    input  logic [DATA_WIDTH-1:0] c_data,
    input  logic                  c_empty,
    output logic                  c_rd,
    output logic [DATA_WIDTH-1:0] y_data,
    input  logic                  y_full,
    output logic                  y_wr,
    output logic                  busy
);

    localparam logic [CNT_WIDTH-1:0] K_LAST = CNT_WIDTH'(DEGREE);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_x;
    logic [CNT_WIDTH-1:0]  r_k;
    logic                  r_x_rd;
    logic                  r_c_rd;
    logic                  r_y_wr;
    logic [DATA_WIDTH-1:0] r_y_data;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] w_mac;

    horner_mac #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mac (
        .i_acc (r_acc),
        .i_x   (r_x),
        .i_c   (c_data),
        .o_y   (w_mac)
    );

    // FIFO data appears the cycle after r_en is sampled, so each read is a
    // request state followed by a state that captures out_data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_x      <= '0;
            r_k      <= '0;
            r_x_rd   <= 1'b0;
            r_c_rd   <= 1'b0;
            r_y_wr   <= 1'b0;
            r_y_data <= '0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!x_empty) begin
                        r_x_rd  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_X_RD;
                    end
                end
                ST_X_RD: begin
                    r_x_rd  <= 1'b0;
                    r_state <= ST_X_LAT;
                end
                ST_X_LAT: begin
                    r_x     <= x_data;
                    r_acc   <= '0;
                    r_k     <= '0;
                    r_state <= ST_C_WAIT;
                end
                ST_C_WAIT: begin
                    if (!c_empty) begin
                        r_c_rd  <= 1'b1;
                        r_state <= ST_C_RD;
                    end
                end
                ST_C_RD: begin
                    r_c_rd  <= 1'b0;
                    r_state <= ST_C_ACC;
                end
                ST_C_ACC: begin
                    r_acc <= w_mac;
                    if (r_k == K_LAST) begin
                        r_state <= ST_Y_CHK;
                    end else begin
                        r_k     <= r_k + 1'b1;
                        r_state <= ST_C_WAIT;
                    end
                end
                ST_Y_CHK: begin
                    if (!y_full) begin
                        r_y_data <= r_acc;
                        r_y_wr   <= 1'b1;
                        r_state  <= ST_Y_WR;
                    end
                end
                ST_Y_WR: begin
                    r_y_wr  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_x_rd  <= 1'b0;
                    r_c_rd  <= 1'b0;
                    r_y_wr  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign x_rd   = r_x_rd;
    assign c_rd   = r_c_rd;
    assign y_wr   = r_y_wr;
    assign y_data = r_y_data;
    assign busy   = r_busy;

endmodule

// File: tb/tb_horner_eval.sv
// tb/tb_horner_eval.sv - self-checking bench for horner_eval with FIFO models and result scoreboard
module tb_horner_eval;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] x_data = 8'h00;
    logic       x_empty = 1'b1;
    logic       x_rd;
    logic [7:0] c_data = 8'h00;
    logic       c_empty = 1'b1;
    logic       c_rd;
    logic [7:0] y_data;
    logic       y_full = 1'b0;
    logic       y_wr;
    logic       busy;

    always #5 clk = ~clk;

    horner_eval #(
        .DATA_WIDTH (8),
        .DEGREE     (3),
        .CNT_WIDTH  (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .x_data  (x_data),
        .x_empty (x_empty),
        .x_rd    (x_rd),
        .c_data  (c_data),
        .c_empty (c_empty),
        .c_rd    (c_rd),
        .y_data  (y_data),
        .y_full  (y_full),
        .y_wr    (y_wr),
        .busy    (busy)
    );

    logic [7:0] xq[$];
    logic [7:0] cq[$];
    logic [7:0] expq[$];
    int         ycq[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         x_rd_cnt = 0;
    int         c_rd_cnt = 0;
    int         y_wr_cnt = 0;
    int         y_last_cyc = 0;
    int         starve_at = -1;
    int         starve_left = 0;
    logic       x_pend = 1'b0;
    logic       c_pend = 1'b0;
    logic [7:0] x_pend_val = 8'h00;
    logic [7:0] c_pend_val = 8'h00;

    // Upstream FIFO models and result-side scoreboard, all updated mid-cycle.
    always @(negedge clk) begin
        logic [7:0] e;
        cyc++;
        if (!reset) begin
            xq.delete();
            cq.delete();
            expq.delete();
            x_pend = 1'b0;
            c_pend = 1'b0;
            x_data = 8'h00;
            c_data = 8'h00;
            starve_left = 0;
        end else begin
            x_data = x_pend ? x_pend_val : 8'h00;
            c_data = c_pend ? c_pend_val : 8'h00;
            x_pend = 1'b0;
            c_pend = 1'b0;
            if (x_rd) begin
                x_rd_cnt++;
                checks++;
                if (xq.size() == 0) begin
                    failures++;
                    $display("FAIL x_underflow: x_rd=1 with empty x-FIFO at cycle %0d", cyc);
                end else begin
                    x_pend_val = xq.pop_front();
                    x_pend = 1'b1;
                end
            end
            if (c_rd) begin
                c_rd_cnt++;
                checks++;
                if (cq.size() == 0) begin
                    failures++;
                    $display("FAIL c_underflow: c_rd=1 with empty c-FIFO at cycle %0d", cyc);
                end else begin
                    c_pend_val = cq.pop_front();
                    c_pend = 1'b1;
                end
                if (c_rd_cnt == starve_at) starve_left = 7;
            end
            if (y_wr) begin
                y_wr_cnt++;
                y_last_cyc = cyc;
                ycq.push_back(cyc);
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL y_unexpected: y_data=%0h with no expected result", y_data);
                end else begin
                    e = expq.pop_front();
                    if (y_data !== e) begin
                        failures++;
                        $display("FAIL y_data: got %0h expected %0h", y_data, e);
                    end
                end
            end
        end
        x_empty = (xq.size() == 0);
        c_empty = (cq.size() == 0) || (starve_left > 0);
        if (starve_left > 0) starve_left--;
    end

    function automatic logic [7:0] ref_eval(input logic [7:0] x, input logic [7:0] c0,
                                            input logic [7:0] c1, input logic [7:0] c2,
                                            input logic [7:0] c3);
        logic [7:0]        cs[4];
        logic [7:0]        a;
        logic signed [15:0] p;
        cs[0] = c0; cs[1] = c1; cs[2] = c2; cs[3] = c3;
        a = 8'h00;
        for (int i = 0; i < 4; i++) begin
            p = $signed({{8{a[7]}}, a}) * $signed({{8{x[7]}}, x}) + $signed({{8{cs[i][7]}}, cs[i]});
            a = p[7:0];
        end
        return a;
    endfunction

    task automatic push_vec(input logic [7:0] x, input logic [7:0] c0, input logic [7:0] c1,
                            input logic [7:0] c2, input logic [7:0] c3, input logic [7:0] exp_y);
        xq.push_back(x);
        cq.push_back(c0);
        cq.push_back(c1);
        cq.push_back(c2);
        cq.push_back(c3);
        expq.push_back(exp_y);
    endtask

    task automatic wait_y(input int target, input int budget, input string name);
        int n = 0;
        while (y_wr_cnt < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (y_wr_cnt < target) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: y_wr count %0d required %0d", name, y_wr_cnt, target);
        end
    endtask

    task automatic wait_c(input int target, input string name);
        int n = 0;
        while (c_rd_cnt < target && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (c_rd_cnt < target) begin
            checks++;
            failures++;
            $display("FAIL %s_c_timeout: c_rd count %0d required %0d", name, c_rd_cnt, target);
        end
    endtask

    task automatic check_latency(input int start_cyc, input int want, input string name);
        checks++;
        if (y_last_cyc - start_cyc - 1 != want) begin
            failures++;
            $display("FAIL %s_latency: got %0d cycles expected %0d", name, y_last_cyc - start_cyc - 1, want);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({x_rd, c_rd, y_wr, busy, y_data} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs: x_rd=%b c_rd=%b y_wr=%b busy=%b y_data=%0h required all 0",
                     x_rd, c_rd, y_wr, busy, y_data);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || x_rd !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b x_rd=%b required 0 0", busy, x_rd);
        end
    endtask

    task automatic test_basic();
        int x0 = x_rd_cnt, c0 = c_rd_cnt, y0 = y_wr_cnt, cs;
        @(posedge clk); #1;
        cs = cyc;
        push_vec(8'd2, 8'd1, 8'd2, 8'd3, 8'd4, 8'h1A);
        wait_y(y0 + 1, 60, "basic");
        check_latency(cs, 16, "basic");
        @(negedge clk); #1;
        checks++;
        if (x_rd_cnt - x0 != 1 || c_rd_cnt - c0 != 4 || y_wr_cnt - y0 != 1) begin
            failures++;
            $display("FAIL basic_pulses: x_rd=%0d c_rd=%0d y_wr=%0d required 1 4 1",
                     x_rd_cnt - x0, c_rd_cnt - c0, y_wr_cnt - y0);
        end
        checks++;
        if (busy !== 1'b0 || y_data !== 8'h1A) begin
            failures++;
            $display("FAIL basic_after: busy=%b y_data=%0h required 0 1a", busy, y_data);
        end
    endtask

    task automatic test_negative_and_wrap();
        int y0 = y_wr_cnt, cs;
        @(posedge clk); #1;
        cs = cyc;
        push_vec(8'hFF, 8'h01, 8'hFE, 8'h03, 8'hFC, 8'hF6);
        wait_y(y0 + 1, 60, "negative");
        check_latency(cs, 16, "negative");
        repeat (2) @(posedge clk);
        #1;
        push_vec(8'd10, 8'd1, 8'd0, 8'd0, 8'd0, 8'hE8);
        wait_y(y0 + 2, 60, "wrap");
        @(negedge clk); #1;
    endtask

    task automatic test_starvation();
        int y0 = y_wr_cnt, base = c_rd_cnt, cs;
        logic stall_ok = 1'b1;
        @(posedge clk); #1;
        cs = cyc;
        starve_at = base + 2;
        push_vec(8'd2, 8'd1, 8'd2, 8'd3, 8'd4, 8'h1A);
        wait_c(base + 2, "starve");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (c_rd !== 1'b0 || busy !== 1'b1) stall_ok = 1'b0;
        end
        checks++;
        if (!stall_ok || c_rd_cnt != base + 2) begin
            failures++;
            $display("FAIL starve_stall: c_rd count %0d required %0d, c_rd low and busy high", c_rd_cnt - base, 2);
        end
        wait_y(y0 + 1, 60, "starve");
        check_latency(cs, 21, "starve");
        starve_at = -1;
        @(negedge clk); #1;
    endtask

    task automatic test_backpressure();
        int y0 = y_wr_cnt, base = c_rd_cnt, cs;
        logic hold_ok = 1'b1;
        @(posedge clk); #1;
        cs = cyc;
        y_full = 1'b1;
        push_vec(8'hFD, 8'h05, 8'h07, 8'hF9, 8'h0B, ref_eval(8'hFD, 8'h05, 8'h07, 8'hF9, 8'h0B));
        wait_c(base + 4, "bp");
        for (int i = 0; i < 6; i++) begin
            if (y_wr !== 1'b0) hold_ok = 1'b0;
            @(negedge clk); #1;
        end
        if (y_wr !== 1'b0) hold_ok = 1'b0;
        checks++;
        if (!hold_ok || y_wr_cnt != y0) begin
            failures++;
            $display("FAIL bp_hold: y_wr count %0d required 0 while full", y_wr_cnt - y0);
        end
        y_full = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (y_wr !== 1'b1 || y_wr_cnt != y0 + 1) begin
            failures++;
            $display("FAIL bp_release: y_wr=%b count %0d required 1 1", y_wr, y_wr_cnt - y0);
        end
        check_latency(cs, 20, "bp");
        @(negedge clk); #1;
        checks++;
        if (y_wr !== 1'b0) begin
            failures++;
            $display("FAIL bp_single_pulse: y_wr=%b required 0", y_wr);
        end
    endtask

    task automatic test_reset_mid();
        int y0, base = c_rd_cnt, cs;
        @(posedge clk); #1;
        push_vec(8'd3, 8'd9, 8'd9, 8'd9, 8'd9, 8'h00);
        wait_c(base + 2, "rmid");
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({x_rd, c_rd, y_wr, busy, y_data} !== 12'h000) begin
            failures++;
            $display("FAIL rmid_outputs: x_rd=%b c_rd=%b y_wr=%b busy=%b y_data=%0h required all 0",
                     x_rd, c_rd, y_wr, busy, y_data);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        y0 = y_wr_cnt;
        @(posedge clk); #1;
        cs = cyc;
        push_vec(8'd2, 8'd1, 8'd2, 8'd3, 8'd4, 8'h1A);
        wait_y(y0 + 1, 60, "rmid");
        check_latency(cs, 16, "rmid");
        @(negedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] v[5];
        int y0 = y_wr_cnt;
        @(posedge clk); #1;
        ycq.delete();
        push_vec(8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80, ref_eval(8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80));
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 5; i++) v[i] = 8'($urandom_range(0, 255));
            push_vec(v[0], v[1], v[2], v[3], v[4], ref_eval(v[0], v[1], v[2], v[3], v[4]));
        end
        wait_y(y0 + 4, 120, "b2b");
        for (int i = 1; i < ycq.size(); i++) begin
            checks++;
            if (ycq[i] - ycq[i-1] != 17) begin
                failures++;
                $display("FAIL b2b_interval: got %0d cycles expected 17", ycq[i] - ycq[i-1]);
            end
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (expq.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: pending=%0d busy=%b required 0 0", expq.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative_and_wrap();
        test_starvation();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
